// File: rtl/aes_ct_serializer_if.sv
// Handshake bundle between the AES ciphertext source, the block serializer and the byte consumer.
// The serializer connects through the slave modport; the driving side uses master.
interface aes_ct_serializer_if;
    logic         ct_valid;
    logic [127:0] ciphertext;
    logic         ct_ready;
    logic [7:0]   dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         ovf;
    logic         clr_ovf;

    modport master (
        output ct_valid, ciphertext, dout_ready, clr_ovf,
        input  ct_ready, dout, dout_valid, dout_last, ovf
    );

    modport slave (
        input  ct_valid, ciphertext, dout_ready, clr_ovf,
        output ct_ready, dout, dout_valid, dout_last, ovf
    );
endinterface

// File: rtl/aes_ct_serializer.sv
// Buffers 128-bit AES ciphertext blocks in a small FIFO and streams them out one byte at a time.
// Define AES_CT_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module aes_ct_serializer #(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset,
    aes_ct_serializer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    logic [127:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [3:0]    byte_idx_r;
    logic [7:0]    dout_r;
    logic          dout_valid_r;
    logic          dout_last_r;
    logic          ct_ready_r;

    logic          full_s;
    logic          push_s;
    logic          xfer_s;
    logic          pop_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [3:0]    byte_idx_nxt_s;
    logic [127:0]  head_nxt_s;

    function automatic logic [7:0] byte_sel(input logic [127:0] blk, input logic [3:0] idx);
        logic [3:0]   pos;
        logic [127:0] shifted;
        pos     = MSB_FIRST ? (4'd15 - idx) : idx;
        shifted = blk >> {pos, 3'b000};
        return shifted[7:0];
    endfunction

    // Next-state of pointers, occupancy and byte position; head_nxt_s is the block shown after the edge.
    always_comb begin
        full_s = (count_r == CNT_FULL);
        push_s = bus.ct_valid && !full_s;
        xfer_s = (count_r != CNT_ZERO) && bus.dout_ready;
        pop_s  = xfer_s && (byte_idx_r == 4'd15);

        wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

        if (pop_s) begin
            byte_idx_nxt_s = 4'd0;
        end else if (xfer_s) begin
            byte_idx_nxt_s = byte_idx_r + 4'd1;
        end else begin
            byte_idx_nxt_s = byte_idx_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // The slot being written this edge becomes the head when the FIFO drains into it.
        if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = bus.ciphertext;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Block storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.ciphertext;
        end
    end

    // Control state and registered byte-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= CNT_ZERO;
            byte_idx_r   <= 4'd0;
            dout_r       <= 8'd0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            ct_ready_r   <= 1'b1;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            byte_idx_r   <= byte_idx_nxt_s;
            dout_valid_r <= (count_nxt_s != CNT_ZERO);
            dout_r       <= (count_nxt_s != CNT_ZERO) ? byte_sel(head_nxt_s, byte_idx_nxt_s) : 8'd0;
            dout_last_r  <= (count_nxt_s != CNT_ZERO) && (byte_idx_nxt_s == 4'd15);
            ct_ready_r   <= (count_nxt_s != CNT_FULL);
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout_last  = dout_last_r;
    assign bus.ct_ready   = ct_ready_r;

`ifdef AES_CT_OVF_EN
    logic ovf_r;

    // Sticky drop indicator; a clear request wins over a same-cycle drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (bus.clr_ovf) begin
            ovf_r <= 1'b0;
        end else if (bus.ct_valid && full_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_aes_ct_serializer.sv
// Bench for aes_ct_serializer: MSB-first and LSB-first instances share stimulus and are compared
// every cycle against a queue-of-blocks reference model.
module tb_aes_ct_serializer;
    localparam int DEPTH = 2;
    localparam logic [127:0] V1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ct_valid = 1'b0;
    logic [127:0] ciphertext = 128'd0;
    logic         dout_ready = 1'b0;
    logic         clr_ovf = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    logic [127:0] q[$];
    int           pos = 0;
    bit           ovf_m = 1'b0;

    aes_ct_serializer_if bus_m ();
    aes_ct_serializer_if bus_l ();

    assign bus_m.ct_valid   = ct_valid;
    assign bus_m.ciphertext = ciphertext;
    assign bus_m.dout_ready = dout_ready;
    assign bus_m.clr_ovf    = clr_ovf;
    assign bus_l.ct_valid   = ct_valid;
    assign bus_l.ciphertext = ciphertext;
    assign bus_l.dout_ready = dout_ready;
    assign bus_l.clr_ovf    = clr_ovf;

    aes_ct_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus_m));
    aes_ct_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(bus_l));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_byte(input logic [127:0] b, input int p, input bit msb);
        int sh;
        sh = msb ? 8 * (15 - p) : 8 * p;
        return 8'((b >> sh) & 128'hff);
    endfunction

    // Reference: apply one clock edge's worth of rules to the block queue.
    task automatic model_step();
        bit full, push, xfer;
        full = (q.size() == DEPTH);
        push = ct_valid && !full;
        xfer = (q.size() != 0) && dout_ready;
`ifdef AES_CT_OVF_EN
        if (clr_ovf) ovf_m = 1'b0;
        else if (ct_valid && full) ovf_m = 1'b1;
`endif
        if (xfer) begin
            pos++;
            if (pos == 16) begin
                pos = 0;
                q.delete(0);
            end
        end
        if (push) q.push_back(ciphertext);
    endtask

    task automatic compare_all();
        bit v;
        v = (q.size() != 0);
        check("dout_valid", bus_m.dout_valid, v);
        check("dout_valid_lsb", bus_l.dout_valid, v);
        check("dout", bus_m.dout, v ? exp_byte(q[0], pos, 1'b1) : 8'd0);
        check("dout_lsb", bus_l.dout, v ? exp_byte(q[0], pos, 1'b0) : 8'd0);
        check("dout_last", bus_m.dout_last, v && (pos == 15));
        check("dout_last_lsb", bus_l.dout_last, v && (pos == 15));
        check("ct_ready", bus_m.ct_ready, q.size() < DEPTH);
        check("ct_ready_lsb", bus_l.ct_ready, q.size() < DEPTH);
        check("ovf", bus_m.ovf, ovf_m);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_until_pos(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (q.size() != 0 && pos == target) break;
            cycle();
        end
        if (i == budget) check("wait_budget", 1'b0, 1'b1);
    endtask

    initial begin
        // reset state
        @(posedge clk);
        #1;
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();

        // single block, continuous ready
        dout_ready = 1'b1;
        ct_valid = 1'b1;
        ciphertext = V1;
        cycle();
        ct_valid = 1'b0;
        check("first_byte_msb", bus_m.dout, 8'h69);
        check("first_byte_lsb", bus_l.dout, 8'h5a);
        repeat (17) cycle();

        // backpressure toggling
        dout_ready = 1'b0;
        ct_valid = 1'b1;
        cycle();
        ct_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            dout_ready = (i % 2 == 0);
            cycle();
        end

        // fill and overflow
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ct_valid = 1'b1;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        ct_valid = 1'b0;
        cycle();
        dout_ready = 1'b1;
        repeat (36) cycle();
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        cycle();

        // push coinciding with final-byte pop, one block queued
        ct_valid = 1'b1;
        ciphertext = V1;
        cycle();
        ct_valid = 1'b0;
        run_until_pos(15, 20);
        ct_valid = 1'b1;
        ciphertext = V2;
        cycle();
        ct_valid = 1'b0;
        check("bypass_next_block", bus_m.dout, 8'h00);
        repeat (17) cycle();

        // same, FIFO full: push dropped
        dout_ready = 1'b0;
        ct_valid = 1'b1;
        ciphertext = V1;
        cycle();
        ciphertext = V2;
        cycle();
        ct_valid = 1'b0;
        dout_ready = 1'b1;
        run_until_pos(15, 20);
        check("ct_ready_full_pop", bus_m.ct_ready, 1'b0);
        ct_valid = 1'b1;
        ciphertext = 128'hdeadbeef_00000000_00000000_cafef00d;
        cycle();
        ct_valid = 1'b0;
        repeat (20) cycle();
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;

        // asynchronous reset during byte 7
        ct_valid = 1'b1;
        ciphertext = V1;
        cycle();
        ct_valid = 1'b0;
        run_until_pos(7, 20);
        check("byte7_before_reset", bus_m.dout, exp_byte(V1, 7, 1'b1));
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        pos = 0;
        ovf_m = 1'b0;
        check("rst_dout_valid", bus_m.dout_valid, 1'b0);
        check("rst_ct_ready", bus_m.ct_ready, 1'b1);
        check("rst_ovf", bus_m.ovf, 1'b0);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        repeat (3) cycle();
        ct_valid = 1'b1;
        ciphertext = V2;
        cycle();
        ct_valid = 1'b0;
        check("post_reset_msb", bus_m.dout, 8'h00);
        check("post_reset_lsb", bus_l.dout, 8'hff);
        repeat (17) cycle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ct_valid = ($urandom_range(0, 2) == 0);
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            dout_ready = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
